// File: rtl/sys_ctrl.sv
// sys_ctrl: decodes UART command frames into register-file writes/reads
// and hands read data to the UART transmitter.
module sys_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] WR_CMD = 8'hAA,
   parameter logic [DATA_WIDTH-1:0] RD_CMD = 8'hBB,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic                  WrEN,
   output logic                  RdEN,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_Valid,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_busy,
   output logic                  cmd_err,
   output logic                  overrun
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n, address_n;
   logic [DATA_WIDTH-1:0] wr_data_n, tx_data_n;
   logic wr_en_n, rd_en_n, tx_vld_n, err_n, ovr_n;
   always_comb begin
      state_n   = state;
      cnt_n     = '0;
      wr_addr_n = wr_addr;
      address_n = address;
      wr_data_n = WrData;
      tx_data_n = TX_P_DATA;
      wr_en_n   = 1'b0;
      rd_en_n   = 1'b0;
      tx_vld_n  = 1'b0;
      err_n     = 1'b0;
      ovr_n     = 1'b0;
      case (state)
         IDLE: if (RX_D_VLD) begin
            state_n = (RX_P_DATA == WR_CMD) ? WR_ADDR : (RX_P_DATA == RD_CMD) ? RD_ADDR : IDLE;
            err_n   = (RX_P_DATA != WR_CMD) && (RX_P_DATA != RD_CMD);
         end
         // write address is held privately so the port only moves with WrEN
         WR_ADDR: if (RX_D_VLD) begin
            wr_addr_n = RX_P_DATA[ADDR_WIDTH-1:0];
            state_n   = WR_DATA;
         end
         WR_DATA: if (RX_D_VLD) begin
            address_n = wr_addr;
            wr_data_n = RX_P_DATA;
            wr_en_n   = 1'b1;
            state_n   = IDLE;
         end
         RD_ADDR: if (RX_D_VLD) begin
            address_n = RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_n   = 1'b1;
            state_n   = RD_WAIT;
         end
         RD_WAIT: begin
            ovr_n = RX_D_VLD;
            if (RdData_Valid) begin
               tx_data_n = RdData;
               state_n   = TX_WAIT;
            end
         end
         TX_WAIT: begin
            ovr_n = RX_D_VLD;
            if (!TX_busy) begin
               tx_vld_n = 1'b1;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // inter-byte timeout only runs while a frame is being collected
      if ((state == WR_ADDR || state == WR_DATA || state == RD_ADDR) && !RX_D_VLD) begin
         if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            err_n   = 1'b1;
            state_n = IDLE;
         end else
            cnt_n = cnt + CW'(1);
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         wr_addr   <= '0;
         address   <= '0;
         WrData    <= '0;
         TX_P_DATA <= '0;
         WrEN      <= 1'b0;
         RdEN      <= 1'b0;
         TX_D_VLD  <= 1'b0;
         cmd_err   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         wr_addr   <= wr_addr_n;
         address   <= address_n;
         WrData    <= wr_data_n;
         TX_P_DATA <= tx_data_n;
         WrEN      <= wr_en_n;
         RdEN      <= rd_en_n;
         TX_D_VLD  <= tx_vld_n;
         cmd_err   <= err_n;
         overrun   <= ovr_n;
      end
endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: table-driven frames plus corner-case sequences, checked by a
// per-event scoreboard against a simple register-file environment.
module tb_sys_ctrl;
   localparam int T = 16;
   localparam int F_WR = 0, F_RD = 1, F_BAD = 2;
   logic clk = 1'b0, reset = 1'b0;
   logic [7:0] RX_P_DATA = 8'h00, RdData;
   logic RX_D_VLD = 1'b0, RdData_Valid, TX_busy = 1'b0;
   logic WrEN, RdEN, TX_D_VLD, cmd_err, overrun;
   logic [3:0] address;
   logic [7:0] WrData, TX_P_DATA;
   int cyc = 0, n_pass = 0, n_tot = 0;

   sys_ctrl #(.TIMEOUT_CYC(T)) dut (
      .clk(clk), .reset(reset), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .WrEN(WrEN), .RdEN(RdEN), .address(address), .WrData(WrData),
      .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_P_DATA(TX_P_DATA),
      .TX_D_VLD(TX_D_VLD), .TX_busy(TX_busy), .cmd_err(cmd_err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // register file environment with its power-on defaults
   logic [7:0] mem [16];
   always @(posedge clk or negedge reset)
      if (!reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= (i == 2) ? 8'h41 : (i == 3) ? 8'h08 : 8'h00;
         RdData <= 8'h00;
         RdData_Valid <= 1'b0;
      end else begin
         RdData_Valid <= RdEN;
         if (RdEN) RdData <= mem[address];
         if (WrEN) mem[address] <= WrData;
      end

   typedef struct { logic [7:0] a; logic [7:0] d; int c; } ev_t;
   ev_t q_wr[$], q_rd[$], q_tx[$], q_err[$], q_ovr[$];

   typedef struct { int n; logic [23:0] bytes; int kind; logic [7:0] ea; logic [7:0] ed; } vec_t;
   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, got, exp);
   endtask

   task automatic bad(input string msg);
      n_tot++;
      $display("FAIL %s at cycle %0d", msg, cyc);
   endtask

   task automatic take(input int k, input logic [7:0] a, input logic [7:0] d);
      ev_t e;
      int n;
      string nm;
      n  = k == 0 ? q_wr.size() : k == 1 ? q_rd.size() : k == 2 ? q_tx.size() : k == 3 ? q_err.size() : q_ovr.size();
      nm = k == 0 ? "WrEN" : k == 1 ? "RdEN" : k == 2 ? "TX_D_VLD" : k == 3 ? "cmd_err" : "overrun";
      if (n == 0) begin
         bad({"unexpected ", nm, " pulse: got 1 want 0"});
         return;
      end
      case (k)
         0: e = q_wr.pop_front();
         1: e = q_rd.pop_front();
         2: e = q_tx.pop_front();
         3: e = q_err.pop_front();
         default: e = q_ovr.pop_front();
      endcase
      chk({nm, " {addr,data,cycle}"}, {a, d, 16'(cyc)}, {e.a, e.d, 16'(e.c < 0 ? cyc : e.c)});
   endtask

   always @(negedge clk) if (reset) begin
      if (WrEN && RdEN) bad("WrEN and RdEN together: got 1 want 0");
      if (WrEN) take(0, {4'h0, address}, WrData);
      if (RdEN) take(1, {4'h0, address}, 8'h00);
      if (TX_D_VLD) take(2, 8'h00, TX_P_DATA);
      if (cmd_err) take(3, 8'h00, 8'h00);
      if (overrun) take(4, 8'h00, 8'h00);
   end

   function automatic logic [31:0] outs();
      return {7'h0, WrEN, RdEN, address, WrData, TX_P_DATA, TX_D_VLD, cmd_err, overrun};
   endfunction

   task automatic send(input logic [7:0] b);
      RX_P_DATA = b;
      RX_D_VLD = 1'b1;
      @(negedge clk);
      RX_D_VLD = 1'b0;
   endtask

   task automatic wait_tx();
      int i = 0;
      while (q_tx.size() != 0 && i < 40) begin
         @(negedge clk);
         i++;
      end
      if (q_tx.size() != 0) begin
         bad("TX_D_VLD never came: got 0 want 1");
         q_tx.delete();
      end
   endtask

   initial begin
      tbl = '{
         '{2, 24'hBB0300, F_RD,  8'h03, 8'h08},
         '{3, 24'hAA053C, F_WR,  8'h05, 8'h3C},
         '{2, 24'hBB0500, F_RD,  8'h05, 8'h3C},
         '{1, 24'h550000, F_BAD, 8'h00, 8'h00},
         '{3, 24'hAA0FA5, F_WR,  8'h0F, 8'hA5},
         '{2, 24'hBB0F00, F_RD,  8'h0F, 8'hA5},
         '{3, 24'hAAF677, F_WR,  8'h06, 8'h77},
         '{2, 24'hBB0600, F_RD,  8'h06, 8'h77},
         '{2, 24'hBB0000, F_RD,  8'h00, 8'h00},
         '{3, 24'hAA35C3, F_WR,  8'h05, 8'hC3},
         '{2, 24'hBB0500, F_RD,  8'h05, 8'hC3},
         '{2, 24'hBB0200, F_RD,  8'h02, 8'h41}
      };
      repeat (3) @(negedge clk);
      chk("reset outputs", outs(), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      // table frames; write frames run back-to-back with no gap
      foreach (tbl[i]) begin
         for (int j = 0; j < tbl[i].n - 1; j++) send(tbl[i].bytes[23-8*j -: 8]);
         case (tbl[i].kind)
            F_WR: q_wr.push_back(ev_t'{tbl[i].ea, tbl[i].ed, cyc + 1});
            F_RD: begin
               q_rd.push_back(ev_t'{tbl[i].ea, 8'h00, cyc + 1});
               q_tx.push_back(ev_t'{8'h00, tbl[i].ed, cyc + 4});
            end
            default: q_err.push_back(ev_t'{8'h00, 8'h00, cyc + 1});
         endcase
         send(tbl[i].bytes[23-8*(tbl[i].n-1) -: 8]);
         if (tbl[i].kind == F_RD) wait_tx();
      end
      // busy transmitter with a byte injected while waiting
      TX_busy = 1'b1;
      send(8'hBB);
      q_rd.push_back(ev_t'{8'h02, 8'h00, cyc + 1});
      send(8'h02);
      repeat (4) @(negedge clk);
      q_ovr.push_back(ev_t'{8'h00, 8'h00, cyc + 1});
      send(8'h11);
      repeat (14) @(negedge clk);
      q_tx.push_back(ev_t'{8'h00, 8'h41, cyc + 1});
      TX_busy = 1'b0;
      wait_tx();
      // write frame times out after the address byte
      send(8'hAA);
      q_err.push_back(ev_t'{8'h00, 8'h00, cyc + 1 + T});
      send(8'h07);
      repeat (T + 3) @(negedge clk);
      send(8'hBB);
      q_rd.push_back(ev_t'{8'h07, 8'h00, cyc + 1});
      q_tx.push_back(ev_t'{8'h00, 8'h00, cyc + 4});
      send(8'h07);
      wait_tx();
      // data byte after T-1 idle cycles is still accepted
      send(8'hAA);
      send(8'h08);
      repeat (T - 1) @(negedge clk);
      q_wr.push_back(ev_t'{8'h08, 8'h5A, cyc + 1});
      send(8'h5A);
      // read frame times out after the command byte
      q_err.push_back(ev_t'{8'h00, 8'h00, cyc + 1 + T});
      send(8'hBB);
      repeat (T + 3) @(negedge clk);
      // reset in the middle of a write frame
      send(8'hAA);
      send(8'h04);
      reset = 1'b0;
      @(negedge clk);
      chk("outputs in reset", outs(), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      q_err.push_back(ev_t'{8'h00, 8'h00, cyc + 1});
      send(8'h9A);
      repeat (5) @(negedge clk);
      chk("pending expectations", q_wr.size() + q_rd.size() + q_tx.size() + q_err.size() + q_ovr.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
